obufds_ser_tx: RTL and testbench

- Differential serial transmitter. It takes parallel words through a valid/ready handshake and shifts them out one bit per clock on a complementary output pair O/OB.
- It is the driving end of the differential input buffer primitives (IBUFGDS family). Board-level test benches and loopback models use it to stimulate those buffers.
- O and OB are never equal after the first clock edge with RST high. A downstream differential receiver therefore never sees an ambiguous (hold) condition.

---
 rtl/obufds_ser_tx.sv | 135 +++++++++++++
 tb/tb_obufds_ser_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/obufds_ser_tx.sv
`default_nettype none
// ============================================================================
//  Module      : obufds_ser_tx
//  Description : Differential serial transmitter. Accepts parallel words over
//                a valid/ready handshake and shifts them out one bit per clock
//                on a complementary pair O/OB. Words can follow each other
//                with no idle gap between them.
//  Revision    : 1.0 - initial release
// ============================================================================
module obufds_ser_tx #(
    parameter int   WIDTH      = 8,     // bits per word, 2..32
    parameter logic IDLE_LEVEL = 1'b0,  // level on O while nothing is shifting
    parameter int   MSB_FIRST  = 1      // 1: DI[WIDTH-1] first, 0: DI[0] first
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DVALID,
    output logic             DREADY,
    output logic             O,
    output logic             OB,
    output logic             BUSY
);

    localparam int                 CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   C_ONE  = CNT_W'(1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sreg;     // bits still to be sent, next one at the output end
    logic             r_o;
    logic             r_busy;

    logic             w_xfer;
    logic             w_last;
    logic             w_load_bit;
    logic [WIDTH-1:0] w_load_rest;
    logic             w_shift_bit;
    logic [WIDTH-1:0] w_shift_rest;

    assign w_xfer = DVALID && DREADY;
    assign w_last = (r_state == S_SHIFT) && (r_cnt == C_LAST);

    // The first bit goes straight to the output register on capture, so the
    // shift register only ever holds the bits that are still pending.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_load_bit   = DI[WIDTH-1];
            assign w_load_rest  = {DI[WIDTH-2:0], 1'b0};
            assign w_shift_bit  = r_sreg[WIDTH-1];
            assign w_shift_rest = {r_sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_load_bit   = DI[0];
            assign w_load_rest  = {1'b0, DI[WIDTH-1:1]};
            assign w_shift_bit  = r_sreg[0];
            assign w_shift_rest = {1'b0, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a transfer in the last bit cycle keeps us in SHIFT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last && !w_xfer) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Ready is a pure function of state, count and reset, never of DVALID
    always_comb begin
        DREADY = 1'b0;
        if (!RST) begin
            DREADY = (r_state == S_IDLE) || w_last;
        end
    end

    // Datapath: capture, shift, bit counting and the registered serial output
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= '0;
            r_sreg <= '0;
            r_o    <= IDLE_LEVEL;
            r_busy <= 1'b0;
        end else if (w_xfer) begin
            r_cnt  <= '0;
            r_sreg <= w_load_rest;
            r_o    <= w_load_bit;
            r_busy <= 1'b1;
        end else if (r_state == S_SHIFT) begin
            if (w_last) begin
                r_cnt  <= '0;
                r_sreg <= '0;
                r_o    <= IDLE_LEVEL;
                r_busy <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + C_ONE;
                r_sreg <= w_shift_rest;
                r_o    <= w_shift_bit;
                r_busy <= 1'b1;
            end
        end
    end

    // Both legs come from the same flop so the pair can never agree
    assign O    = r_o;
    assign OB   = ~r_o;
    assign BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_obufds_ser_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obufds_ser_tx
//  Description : Directed self-checking bench for obufds_ser_tx. One instance
//                uses the defaults (8 bit, MSB first, idle low), a second one
//                is 4 bit, LSB first, idle high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_obufds_ser_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, dvalid, dready, o, ob, busy;
    logic [7:0] di;
    logic       rst4, dv4, dready4, o4, ob4, busy4;
    logic [3:0] di4;

    int n_vec = 0;
    int n_err = 0;
    bit armed = 1'b0;

    obufds_ser_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0), .MSB_FIRST(1)) dut (
        .CLK(clk), .RST(rst), .DI(di), .DVALID(dvalid),
        .DREADY(dready), .O(o), .OB(ob), .BUSY(busy)
    );

    obufds_ser_tx #(.WIDTH(4), .IDLE_LEVEL(1'b1), .MSB_FIRST(0)) dut4 (
        .CLK(clk), .RST(rst4), .DI(di4), .DVALID(dv4),
        .DREADY(dready4), .O(o4), .OB(ob4), .BUSY(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pair must differ in every cycle once a reset edge has been seen
    always @(posedge clk) if (rst && rst4) armed = 1'b1;

    always @(negedge clk) begin
        if (armed) begin
            chk("o_ne_ob", 32'(o ^ ob), 32'd1);
            chk("o4_ne_ob4", 32'(o4 ^ ob4), 32'd1);
        end
    end

    task automatic idle_chk(input string tag);
        chk({tag, "_o"}, 32'(o), 32'd0);
        chk({tag, "_ob"}, 32'(ob), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Checks 8 bit cycles of a word on the default instance, DVALID low
    task automatic shift8(input string tag, input logic [7:0] seq);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_o"}, 32'(o), 32'(seq[7-i]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_rdy"}, 32'(dready), 32'(i == 7));
            @(negedge clk);
        end
    endtask

    task automatic shift4(input string tag, input logic [3:0] seq);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_o"}, 32'(o4), 32'(seq[3-i]));
            chk({tag, "_busy"}, 32'(busy4), 32'd1);
            chk({tag, "_rdy"}, 32'(dready4), 32'(i == 3));
            @(negedge clk);
        end
        chk({tag, "_idle_o"}, 32'(o4), 32'd1);
        chk({tag, "_idle_ob"}, 32'(ob4), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy4), 32'd0);
    endtask

    initial begin
        rst = 1'b1; dvalid = 1'b0; di = '0;
        rst4 = 1'b1; dv4 = 1'b0; di4 = '0;

        // Reset for two cycles
        @(negedge clk);
        idle_chk("rst");
        chk("rst_rdy", 32'(dready), 32'd0);
        chk("rst4_o", 32'(o4), 32'd1);
        chk("rst4_ob", 32'(ob4), 32'd0);
        chk("rst4_busy", 32'(busy4), 32'd0);
        chk("rst4_rdy", 32'(dready4), 32'd0);
        @(negedge clk);
        idle_chk("rst2");
        chk("rst2_rdy", 32'(dready), 32'd0);
        rst = 1'b0; rst4 = 1'b0;
        #1;
        chk("rel_rdy", 32'(dready), 32'd1);
        chk("rel4_rdy", 32'(dready4), 32'd1);

        // Idle for ten cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_chk("idle");
            chk("idle_rdy", 32'(dready), 32'd1);
        end

        // Single word 8'hA5
        di = 8'hA5; dvalid = 1'b1;
        #1 chk("a5_rdy0", 32'(dready), 32'd1);
        @(negedge clk);
        dvalid = 1'b0;
        shift8("a5", 8'b10100101);
        idle_chk("a5_end");

        // Back-to-back 8'hFF then 8'h00 with DVALID held high
        di = 8'hFF; dvalid = 1'b1;
        @(negedge clk);
        di = 8'h00;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_o", 32'(o), 32'(i < 8));
            chk("b2b_busy", 32'(busy), 32'd1);
            chk("b2b_rdy", 32'(dready), 32'((i % 8) == 7));
            if (i == 8) dvalid = 1'b0;
            @(negedge clk);
        end
        idle_chk("b2b_end");

        // Stall: DI keeps changing while not ready, then 8'h5A in the last cycle
        di = 8'hF0; dvalid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("stall_o", 32'(o), 32'(i < 4));
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_rdy", 32'(dready), 32'(i == 7));
            di = (i == 7) ? 8'h5A : 8'(i * 55 + 17);
            @(negedge clk);
        end
        dvalid = 1'b0;
        shift8("5a", 8'b01011010);
        idle_chk("5a_end");

        // Reset during bit 3 of 8'h3C, then 8'h81
        di = 8'h3C; dvalid = 1'b1;
        @(negedge clk);
        dvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid_o", 32'(o), 32'(i == 2));
            @(negedge clk);
        end
        chk("mid_bit3", 32'(o), 32'd1);
        rst = 1'b1;
        #1 chk("mid_rst_rdy", 32'(dready), 32'd0);
        @(negedge clk);
        idle_chk("mid_rst");
        chk("mid_rst_rdy2", 32'(dready), 32'd0);
        rst = 1'b0; di = 8'h81; dvalid = 1'b1;
        #1 chk("mid_rel_rdy", 32'(dready), 32'd1);
        @(negedge clk);
        dvalid = 1'b0;
        shift8("81", 8'b10000001);
        idle_chk("81_end");

        // 4-bit LSB-first instance, idle high
        di4 = 4'b0001; dv4 = 1'b1;
        #1 chk("w4_rdy0", 32'(dready4), 32'd1);
        @(negedge clk);
        dv4 = 1'b0;
        shift4("w4a", 4'b1000);
        di4 = 4'b0110; dv4 = 1'b1;
        @(negedge clk);
        dv4 = 1'b0;
        shift4("w4b", 4'b0110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
